router_msg_buffer: RTL and testbench

- One inbound message slot of the router. Receives a bit-serial message (start bit, cell address, payload) from the router wire and holds it until the identifier grants delivery.
- Then shifts the payload out one bit per cycle to the distributor, with the held cell address presented alongside.
- Seven instances feed the distributor, one per buffer lane; each provides that lane's bit/addr pair and raises a delivery request to the identifier.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_msg_buffer_if.sv | 37 +++
 rtl/router_shift_reg.sv | 21 ++
 rtl/router_msg_buffer.sv | 144 ++++++++++++++
 tb/tb_router_msg_buffer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router message slots: default address width,
// lane count, the slot FSM state encoding and the counter-width helper.
package router_pkg;

  localparam int ROUTER_ADDR_W = 4;
  localparam int ROUTER_LANES  = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_ADDR = 3'd1,
    ST_RX_DATA = 3'd2,
    ST_RX_PAR  = 3'd3,
    ST_FULL    = 3'd4,
    ST_TX      = 3'd5
  } router_buf_state_t;

  // Bit counter width: one bit wider than needed to index the longer field.
  function automatic int router_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/router_msg_buffer_if.sv
// Signal bundle between one message slot, its inbound router wire, the
// identifier (request/grant) and the distributor (bit/addr).
//
// Handshakes:
//   - rx_valid qualifies rx_bit for one cycle. busy is the backpressure:
//     while busy is high the slot drops any rx_valid bit, so the upstream
//     link must hold off until busy falls.
//   - deliver_req is held high while a complete message is stored. sel is
//     the grant; while sel stays high the payload streams out on bit_out.
//     Dropping sel mid-stream aborts, and the next grant restarts at the MSB.
interface router_msg_buffer_if
  import router_pkg::*;
#(
  parameter int ADDR_W = ROUTER_ADDR_W
) ();

  logic              rx_valid;
  logic              rx_bit;
  logic              busy;
  logic              deliver_req;
  logic              sel;
  logic [ADDR_W-1:0] cell_addr;
  logic              bit_out;
  logic              done;
  logic              err;

  modport master (
    output rx_valid, rx_bit, sel,
    input  busy, deliver_req, cell_addr, bit_out, done, err
  );

  modport slave (
    input  rx_valid, rx_bit, sel,
    output busy, deliver_req, cell_addr, bit_out, done, err
  );

endinterface

// File: rtl/router_shift_reg.sv
// MSB-first serial-in, parallel-out shift register with synchronous reset.
module router_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  // Shift din in at the LSB end on each enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= (q << 1) | W'(din);
    end
  end

endmodule

// File: rtl/router_msg_buffer.sv
// One inbound message slot of the router: receives start bit, cell address
// and payload serially, holds the message, and streams the payload to the
// distributor once the identifier grants delivery.
// Optional feature macro: ROUTER_PARITY_EN adds a trailing even-parity bit
// over address+payload; a mismatch pulses err and drops the message.
module router_msg_buffer
  import router_pkg::*;
#(
  parameter int ADDR_W = ROUTER_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  router_msg_buffer_if.slave   bus,
  output router_buf_state_t    state_dbg
);

  localparam int CNT_W = router_cnt_w(ADDR_W, DATA_W);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  router_buf_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              addr_en, data_en;
  logic              done_c, err_c;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  tx_idx;

  router_shift_reg #(.W(ADDR_W)) u_addr_sr (
    .clk (clk),
    .rst (rst),
    .en  (addr_en),
    .din (bus.rx_bit),
    .q   (addr_q)
  );

  router_shift_reg #(.W(DATA_W)) u_data_sr (
    .clk (clk),
    .rst (rst),
    .en  (data_en),
    .din (bus.rx_bit),
    .q   (data_q)
  );

  // State and bit counter registers; reset discards any partial message.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter and shift-enable decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_en = 1'b0;
    data_en = 1'b0;
    done_c  = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.rx_valid && bus.rx_bit) state_d = ST_RX_ADDR;
      end
      ST_RX_ADDR: begin
        if (bus.rx_valid) begin
          addr_en = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = ST_RX_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RX_DATA: begin
        if (bus.rx_valid) begin
          data_en = 1'b1;
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
`ifdef ROUTER_PARITY_EN
            state_d = ST_RX_PAR;
`else
            state_d = ST_FULL;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RX_PAR: begin
`ifdef ROUTER_PARITY_EN
        if (bus.rx_valid) begin
          if ((^{addr_q, data_q}) == bus.rx_bit) begin
            state_d = ST_FULL;
          end else begin
            err_c   = 1'b1;
            state_d = ST_IDLE;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_FULL: begin
        cnt_d = '0;
        if (bus.sel) state_d = ST_TX;
      end
      ST_TX: begin
        if (!bus.sel) begin
          // Grant withdrawn: keep the payload, restart from the MSB later.
          state_d = ST_FULL;
          cnt_d   = '0;
        end else if (cnt_q == DATA_LAST) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign tx_idx          = IDX_W'(DATA_W - 1) - IDX_W'(cnt_q);
  assign bus.busy        = (state_q == ST_FULL) || (state_q == ST_TX);
  assign bus.deliver_req = (state_q == ST_FULL) || (state_q == ST_TX);
  assign bus.cell_addr   = addr_q;
  assign bus.bit_out     = (state_q == ST_TX) ? data_q[tx_idx] : 1'b0;
  assign bus.done        = done_c;
  assign bus.err         = err_c;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_router_msg_buffer.sv
// Directed bench for router_msg_buffer with ADDR_W=4, DATA_W=8.
module tb_router_msg_buffer;
  import router_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;

  logic clk;
  logic rst;
  router_buf_state_t state_dbg;
  router_msg_buffer_if #(.ADDR_W(AW)) bus ();

  router_msg_buffer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx_valid = 1'b1;
    bus.rx_bit   = b;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_bit   = 1'b0;
  endtask

  task automatic send_head(input logic [AW-1:0] addr);
    send_bit(1'b1);
    for (int i = AW - 1; i >= 0; i--) send_bit(addr[i]);
  endtask

  task automatic send_data(input logic [DW-1:0] data, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(data[i]);
  endtask

  task automatic send_tail(input logic [AW-1:0] addr, input logic [DW-1:0] data);
`ifdef ROUTER_PARITY_EN
    send_bit(^{addr, data});
`else
    chk("no_par_err", 32'(bus.err), 32'd0);
`endif
  endtask

  // Grant delivery and score the streamed bits against the expected queue.
  task automatic run_tx(input string tag, input logic [DW-1:0] data);
    logic e;
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(data[i]);
    bus.sel = 1'b1;
    tick();
    for (int i = 0; i < DW; i++) begin
      e = exp_q.pop_front();
      chk({tag, "_bit"}, 32'(bus.bit_out), 32'(e));
      chk({tag, "_done"}, 32'(bus.done), 32'(i == DW - 1));
      chk({tag, "_req"}, 32'(bus.deliver_req), 32'd1);
      bus.rx_valid = 1'b1;
      bus.rx_bit   = 1'($urandom_range(0, 1));
      tick();
    end
    bus.rx_valid = 1'b0;
    bus.sel      = 1'b0;
    chk({tag, "_end_state"}, 32'(state_dbg), 32'(ST_IDLE));
    chk({tag, "_end_req"}, 32'(bus.deliver_req), 32'd0);
    chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_end_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_bit   = 1'b0;
    bus.sel      = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_req", 32'(bus.deliver_req), 32'd0);
    chk("rst_addr", 32'(bus.cell_addr), 32'd0);
    chk("rst_bit", 32'(bus.bit_out), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);

    // zeros in IDLE are not a start bit
    send_bit(1'b0);
    send_bit(1'b0);
    chk("idle_zero", 32'(state_dbg), 32'(ST_IDLE));

    // message 1: addr 5, payload 0xB3, contiguous
    send_head(4'h5);
    chk("hdr_state", 32'(state_dbg), 32'(ST_RX_DATA));
    send_data(8'hB3, 7, 1);
    chk("pre_full_req", 32'(bus.deliver_req), 32'd0);
    chk("pre_full_busy", 32'(bus.busy), 32'd0);
    send_data(8'hB3, 0, 0);
    send_tail(4'h5, 8'hB3);
    chk("full_state", 32'(state_dbg), 32'(ST_FULL));
    chk("full_addr", 32'(bus.cell_addr), 32'h5);
    chk("full_req", 32'(bus.deliver_req), 32'd1);
    chk("full_busy", 32'(bus.busy), 32'd1);
    chk("full_bit", 32'(bus.bit_out), 32'd0);

    // bits offered while FULL are ignored
    for (int i = 0; i < 5; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_bit   = 1'($urandom_range(0, 1));
      tick();
    end
    bus.rx_valid = 1'b0;
    chk("ign_state", 32'(state_dbg), 32'(ST_FULL));
    chk("ign_addr", 32'(bus.cell_addr), 32'h5);
    run_tx("tx1", 8'hB3);

    // message 2: stall of 3 cycles mid-payload
    send_head(4'h5);
    send_data(8'hB3, 7, 4);
    tick();
    tick();
    tick();
    chk("stall_state", 32'(state_dbg), 32'(ST_RX_DATA));
    send_data(8'hB3, 3, 0);
    send_tail(4'h5, 8'hB3);
    chk("stall_full", 32'(state_dbg), 32'(ST_FULL));
    run_tx("tx2", 8'hB3);

    // message 3: abort after 3 bits, regrant after 2 idle cycles
    send_head(4'h5);
    send_data(8'hB3, 7, 0);
    send_tail(4'h5, 8'hB3);
    bus.sel = 1'b1;
    tick();
    chk("ab_b0", 32'(bus.bit_out), 32'd1);
    tick();
    chk("ab_b1", 32'(bus.bit_out), 32'd0);
    tick();
    chk("ab_b2", 32'(bus.bit_out), 32'd1);
    bus.sel = 1'b0;
    chk("ab_done0", 32'(bus.done), 32'd0);
    tick();
    chk("ab_state", 32'(state_dbg), 32'(ST_FULL));
    chk("ab_req", 32'(bus.deliver_req), 32'd1);
    chk("ab_bit", 32'(bus.bit_out), 32'd0);
    chk("ab_done1", 32'(bus.done), 32'd0);
    tick();
    chk("ab_state2", 32'(state_dbg), 32'(ST_FULL));
    run_tx("tx3", 8'hB3);

    // reset in RX_DATA after 4 payload bits
    send_head(4'hA);
    send_data(8'h6D, 7, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("mr_addr", 32'(bus.cell_addr), 32'd0);
    chk("mr_req", 32'(bus.deliver_req), 32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    send_head(4'hF);
    send_data(8'h5C, 7, 0);
    send_tail(4'hF, 8'h5C);
    chk("mr_full", 32'(state_dbg), 32'(ST_FULL));
    chk("mr_faddr", 32'(bus.cell_addr), 32'hF);
    run_tx("tx4", 8'h5C);

`ifdef ROUTER_PARITY_EN
    // wrong parity bit: addr 5 + 0xB3 needs parity 1
    send_head(4'h5);
    send_data(8'hB3, 7, 0);
    chk("par_state", 32'(state_dbg), 32'(ST_RX_PAR));
    bus.rx_valid = 1'b1;
    bus.rx_bit   = 1'b0;
    #1;
    chk("par_err", 32'(bus.err), 32'd1);
    tick();
    bus.rx_valid = 1'b0;
    chk("par_idle", 32'(state_dbg), 32'(ST_IDLE));
    chk("par_err_end", 32'(bus.err), 32'd0);
    chk("par_req", 32'(bus.deliver_req), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
